// File: rtl/rom_fetch.sv
// rtl/rom_fetch.sv - ROM fetch engine streaming words to a valid/ready consumer
//
// Fetches `count` words from the registered-output ROM, starting at `base_addr`
// and wrapping at the top of the ROM. Each word goes into a 2-entry buffer and
// is presented downstream with its ROM address.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               one-cycle pulse, accepted only when idle
//   base_addr, count    transfer setup, sampled on an accepted start
//   busy, done          busy while fetching/draining; done pulses one cycle
//   rom_cs, rom_addr    ROM request pins
//   rom_data            ROM read data, valid the cycle after a selected address
//   out_valid/out_ready downstream handshake
//   out_data, out_addr  buffered word and its ROM address
//   checksum            (only with ROM_FETCH_CHECKSUM_EN) running sum of accepted words
//
// Optional feature macro: ROM_FETCH_CHECKSUM_EN
module rom_fetch #(
  parameter int WORDSIZE   = 16,
  parameter int ADDRSIZE   = 5,
  parameter int NUMADDR    = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDRSIZE-1:0] base_addr,
  input  logic [ADDRSIZE:0]   count,
  output logic                busy,
  output logic                done,
  output logic                rom_cs,
  output logic [ADDRSIZE-1:0] rom_addr,
  input  logic [WORDSIZE-1:0] rom_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] out_data,
  output logic [ADDRSIZE-1:0] out_addr
`ifdef ROM_FETCH_CHECKSUM_EN
  ,
  output logic [WORDSIZE-1:0] checksum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDRSIZE:0]   ONE_CNT  = 1;
  localparam logic [ADDRSIZE-1:0] TOP_ADDR = ADDRSIZE'(NUMADDR - 1);
  localparam logic [1:0]          DEPTH    = 2'(FIFO_DEPTH);

  state_t              state_q, state_d;
  logic [ADDRSIZE-1:0] addr_q, addr_next, inflight_addr_q;
  logic [ADDRSIZE:0]   remaining_q, issued_q;
  logic                inflight_q;
  logic                issue;

  logic [WORDSIZE-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDRSIZE-1:0] fifo_addr [FIFO_DEPTH];
  logic                rd_ptr, wr_ptr;
  logic [1:0]          occ_q;
  logic                push, pop;
  logic [1:0]          credit_used;

  assign push      = inflight_q;
  assign pop       = out_valid && out_ready;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_addr  = fifo_addr[rd_ptr];
  assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign addr_next = (addr_q == TOP_ADDR) ? '0 : addr_q + 1'b1;

  // Slots already spoken for once this cycle's pop frees its entry. Counting
  // the pop keeps one read issued per cycle while the consumer keeps up,
  // and the buffer can still never be overrun.
  assign credit_used = occ_q + {1'b0, inflight_q} - {1'b0, pop};

  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    rom_cs   = 1'b0;
    rom_addr = '0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (count == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        rom_cs   = 1'b1;
        rom_addr = addr_q;
        if (credit_used < DEPTH && issued_q < remaining_q) issue = 1'b1;
        if (issue && (issued_q + ONE_CNT) == remaining_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Keep the ROM selected only while its last read is being returned.
        rom_cs = inflight_q;
        // Leave as the final word is handshaken so done follows it by one cycle.
        if (!inflight_q && (occ_q == 2'd0 || (occ_q == 2'd1 && pop))) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      inflight_addr_q <= '0;
      remaining_q     <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (state_q == S_IDLE && start && count != '0) begin
        addr_q      <= base_addr;
        remaining_q <= count;
        issued_q    <= '0;
      end else if (issue) begin
        addr_q          <= addr_next;
        inflight_addr_q <= addr_q;
        issued_q        <= issued_q + ONE_CNT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= rom_data;
        fifo_addr[wr_ptr] <= inflight_addr_q;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

`ifdef ROM_FETCH_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (state_q == S_IDLE && start) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + out_data;
    end
  end
`else
  // Checksum port and adder are not built.
`endif

endmodule

// File: tb/tb_rom_fetch.sv
// tb/tb_rom_fetch.sv - directed self-checking bench for rom_fetch
module tb_rom_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  base_addr;
  logic [5:0]  count;
  logic        busy, done, rom_cs, out_valid, out_ready;
  logic [4:0]  rom_addr, out_addr;
  logic [15:0] rom_data, out_data;
`ifdef ROM_FETCH_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Registered ROM: mem[i] = 16'hA000 + i, data valid the cycle after cs.
  logic [15:0] rom_q;
  logic        rom_oe;
  always @(posedge clk) begin
    rom_oe <= rom_cs;
    if (rom_cs) rom_q <= 16'hA000 + {11'd0, rom_addr};
  end
  assign rom_data = rom_oe ? rom_q : 16'hzzzz;

  rom_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
`ifdef ROM_FETCH_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the first cycle after start was sampled.
  task automatic do_start(input logic [4:0] b, input logic [5:0] c);
    start = 1'b1; base_addr = b; count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
    total++; if (rom_cs !== 1'b0) $display("FAIL reset_rom_cs: got %b expected 0", rom_cs); else passed++;
    total++; if (rom_addr !== 5'd0) $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (out_data !== 16'h0) $display("FAIL reset_out_data: got %h expected 0000", out_data); else passed++;
    total++; if (out_addr !== 5'd0) $display("FAIL reset_out_addr: got %0d expected 0", out_addr); else passed++;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    do_start(5'd3, 6'd4);
    total++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b expected 1", busy); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL basic_valid_c1: got %b expected 0", out_valid); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL basic_valid_c2: got %b expected 0", out_valid); else passed++;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (out_valid !== 1'b1) $display("FAIL basic_valid[%0d]: got %b expected 1", i, out_valid); else passed++;
      total++; if (out_data !== 16'hA003 + 16'(i)) $display("FAIL basic_data[%0d]: got %h expected %h", i, out_data, 16'hA003 + 16'(i)); else passed++;
      total++; if (out_addr !== 5'(3 + i)) $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, out_addr, 3 + i); else passed++;
    end
    tick();
    total++; if (done !== 1'b1) $display("FAIL basic_done: got %b expected 1", done); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL basic_valid_end: got %b expected 0", out_valid); else passed++;
    total++; if (rom_cs !== 1'b0) $display("FAIL basic_cs_end: got %b expected 0", rom_cs); else passed++;
    tick();
    total++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b expected 0", done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_wrap();
    logic [4:0]  ea;
    logic [15:0] ed;
    out_ready = 1'b1;
    do_start(5'd30, 6'd4);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      ea = 5'(30 + i);
      ed = 16'hA000 + {11'd0, ea};
      total++; if (out_valid !== 1'b1 || out_addr !== ea || out_data !== ed)
        $display("FAIL wrap[%0d]: got v=%b addr=%0d data=%h expected v=1 addr=%0d data=%h", i, out_valid, out_addr, out_data, ea, ed);
      else passed++;
    end
    tick();
    total++; if (done !== 1'b1) $display("FAIL wrap_done: got %b expected 1", done); else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    int          n = 0;
    int          k = 0;
    logic        stalled_prev = 1'b0;
    logic        seen_done = 1'b0;
    logic [15:0] prev_data = 16'h0;
    out_ready = 1'b0;
    do_start(5'd0, 6'd6);
    for (int cyc = 0; cyc < 60 && !seen_done; cyc++) begin
      if (done) begin
        seen_done = 1'b1;
      end else begin
        out_ready = (k % 3 == 0);
        k++;
        if (stalled_prev) begin
          total++; if (out_valid !== 1'b1 || out_data !== prev_data)
            $display("FAIL bp_stable: got v=%b data=%h expected v=1 data=%h", out_valid, out_data, prev_data);
          else passed++;
        end
        stalled_prev = 1'b0;
        if (out_valid && out_ready) begin
          total++; if (out_data !== 16'hA000 + 16'(n) || out_addr !== 5'(n))
            $display("FAIL bp_word[%0d]: got addr=%0d data=%h expected addr=%0d data=%h", n, out_addr, out_data, n, 16'hA000 + 16'(n));
          else passed++;
          n++;
        end else if (out_valid) begin
          stalled_prev = 1'b1;
          prev_data = out_data;
          // With at most two words held, fewer than 4 delivered means fetching is not finished.
          if (n <= 3) begin
            total++; if (rom_cs !== 1'b1) $display("FAIL bp_cs_stall: got %b expected 1", rom_cs); else passed++;
          end
        end
        tick();
      end
    end
    total++; if (!seen_done) $display("FAIL bp_timeout: got no done expected done within 60 cycles"); else passed++;
    total++; if (n != 6) $display("FAIL bp_count: got %0d expected 6", n); else passed++;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_count_zero();
    out_ready = 1'b1;
    do_start(5'd5, 6'd0);
    total++; if (done !== 1'b1) $display("FAIL zero_done: got %b expected 1", done); else passed++;
    total++; if (rom_cs !== 1'b0) $display("FAIL zero_cs: got %b expected 0", rom_cs); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b expected 0", busy); else passed++;
    tick();
    total++; if (done !== 1'b0 || rom_cs !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL zero_after: got done=%b cs=%b v=%b expected 0 0 0", done, rom_cs, out_valid);
    else passed++;
  endtask

  task automatic test_mid_reset();
    logic found = 1'b0;
    out_ready = 1'b1;
    do_start(5'd0, 6'd10);
    for (int i = 0; i < 10 && !found; i++) begin
      if (out_valid && out_addr == 5'd2) found = 1'b1;
      else tick();
    end
    total++; if (!found) $display("FAIL mrst_third: got no word at addr 2 expected one within 10 cycles"); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy, done, rom_cs, out_valid} !== 4'b0000)
      $display("FAIL mrst_ctrl: got busy=%b done=%b cs=%b v=%b expected all 0", busy, done, rom_cs, out_valid);
    else passed++;
    total++; if (out_data !== 16'h0 || out_addr !== 5'd0 || rom_addr !== 5'd0)
      $display("FAIL mrst_data: got data=%h addr=%0d rom_addr=%0d expected 0", out_data, out_addr, rom_addr);
    else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    do_start(5'd0, 6'd2);
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL mrst_stale: got v=%b expected 0", out_valid); else passed++;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== 16'hA000 + 16'(i))
        $display("FAIL mrst_word[%0d]: got v=%b data=%h expected v=1 data=%h", i, out_valid, out_data, 16'hA000 + 16'(i));
      else passed++;
    end
    tick();
    total++; if (done !== 1'b1) $display("FAIL mrst_done: got %b expected 1", done); else passed++;
    tick();
  endtask

  task automatic test_full_and_ignore();
    int   n = 0;
    logic seen_done = 1'b0;
    out_ready = 1'b1;
    do_start(5'd0, 6'd32);
    for (int cyc = 0; cyc < 80 && !seen_done; cyc++) begin
      // A start while busy must not disturb the transfer.
      start = (cyc == 3);
      base_addr = 5'd10;
      count = 6'd1;
      if (done) begin
        seen_done = 1'b1;
      end else begin
        if (out_valid) begin
          total++; if (out_addr !== 5'(n) || out_data !== 16'hA000 + 16'(n))
            $display("FAIL full_word[%0d]: got addr=%0d data=%h expected addr=%0d data=%h", n, out_addr, out_data, n, 16'hA000 + 16'(n));
          else passed++;
          n++;
        end
        tick();
      end
    end
    start = 1'b0;
    total++; if (!seen_done) $display("FAIL full_timeout: got no done expected done within 80 cycles"); else passed++;
    total++; if (n != 32) $display("FAIL full_count: got %0d expected 32", n); else passed++;
`ifdef ROM_FETCH_CHECKSUM_EN
    total++; if (checksum !== 16'h01F0) $display("FAIL checksum: got %h expected 01f0", checksum); else passed++;
    tick();
    total++; if (checksum !== 16'h01F0) $display("FAIL checksum_hold: got %h expected 01f0", checksum); else passed++;
    do_start(5'd5, 6'd0);
    total++; if (checksum !== 16'h0) $display("FAIL checksum_clear: got %h expected 0000", checksum); else passed++;
`endif
    tick();
    total++; if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL full_idle: got busy=%b v=%b expected 0 0", busy, out_valid);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = 5'd0; count = 6'd0; out_ready = 1'b1;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_wrap();
    test_backpressure();
    test_count_zero();
    test_mid_reset();
    test_full_and_ignore();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
